// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg: the types and constants that the stopwatch control files share.
//   - sw_state_e : control FSM states
//   - DIGIT_W/TIME_W, digit limits, packed time layout and field offsets
//   - dig_inc    : increments one BCD digit and wraps it back to 0 at its limit
package stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2,
    OVF  = 2'd3
  } sw_state_e;

  localparam int DIGIT_W = 4;
  localparam int TIME_W  = 24;

  localparam logic [DIGIT_W-1:0] DIG_MAX9 = 4'd9;
  localparam logic [DIGIT_W-1:0] DIG_MAX5 = 4'd5;

  // {min_t, min_u, sec_t, sec_u, cs_t, cs_u}
  typedef struct packed {
    logic [DIGIT_W-1:0] min_t;
    logic [DIGIT_W-1:0] min_u;
    logic [DIGIT_W-1:0] sec_t;
    logic [DIGIT_W-1:0] sec_u;
    logic [DIGIT_W-1:0] cs_t;
    logic [DIGIT_W-1:0] cs_u;
  } time_bcd_t;

  localparam int OFS_CS_U  = 0;
  localparam int OFS_CS_T  = 4;
  localparam int OFS_SEC_U = 8;
  localparam int OFS_SEC_T = 12;
  localparam int OFS_MIN_U = 16;
  localparam int OFS_MIN_T = 20;

  localparam logic [TIME_W-1:0] MAX_TIME = 24'h595999;

  function automatic logic [DIGIT_W-1:0] dig_inc(input logic [DIGIT_W-1:0] d,
                                                 input logic [DIGIT_W-1:0] lim);
    return (d == lim) ? '0 : d + 4'd1;
  endfunction

endpackage

// File: rtl/bcd_time_counter.sv
// bcd_time_counter: six-digit mm:ss:cc BCD counter.
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   inc          advance the count by one centisecond
//   clr          synchronous clear (takes priority over inc)
//   sat          when high, an inc at 59:59.99 leaves the count unchanged
//   time_bcd     packed count {min_t,min_u,sec_t,sec_u,cs_t,cs_u}
//   max_reached  count is 59:59.99
module bcd_time_counter
  import stopwatch_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              inc,
  input  logic              clr,
  input  logic              sat,
  output logic [TIME_W-1:0] time_bcd,
  output logic              max_reached
);

  time_bcd_t cnt_q, cnt_d;
  logic      carry;

  assign max_reached = (cnt_q == MAX_TIME);
  assign time_bcd    = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    carry = 1'b0;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && !(sat && max_reached)) begin
      // Each digit only moves when every lower digit is wrapping.
      cnt_d.cs_u = dig_inc(cnt_q.cs_u, DIG_MAX9);
      carry      = (cnt_q.cs_u == DIG_MAX9);
      if (carry) begin
        cnt_d.cs_t = dig_inc(cnt_q.cs_t, DIG_MAX9);
        carry      = (cnt_q.cs_t == DIG_MAX9);
      end
      if (carry) begin
        cnt_d.sec_u = dig_inc(cnt_q.sec_u, DIG_MAX9);
        carry       = (cnt_q.sec_u == DIG_MAX9);
      end
      if (carry) begin
        cnt_d.sec_t = dig_inc(cnt_q.sec_t, DIG_MAX5);
        carry       = (cnt_q.sec_t == DIG_MAX5);
      end
      if (carry) begin
        cnt_d.min_u = dig_inc(cnt_q.min_u, DIG_MAX9);
        carry       = (cnt_q.min_u == DIG_MAX9);
      end
      if (carry) begin
        cnt_d.min_t = dig_inc(cnt_q.min_t, DIG_MAX5);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: button edge detection, start/stop/reset FSM, 100 Hz
// prescaler and BCD elapsed time for the sprinter stopwatch.
// Optional feature: define STOPWATCH_LAP_EN to enable lap capture; without it
// btn_lap is ignored and lap_bcd/lap_valid stay 0.
// Ports:
//   clk, rst                              clock, asynchronous active-high reset
//   btn_start_stop, btn_reset, btn_lap    debounced button levels (high = pressed)
//   running, ovf                          high in RUN / OVF
//   time_bcd                              elapsed time mm:ss:cc, packed BCD
//   lap_bcd, lap_valid                    last lap time and its one-cycle update pulse
//
// state | meaning
// IDLE  | cleared, waiting for start
// RUN   | prescaler counting, time advancing
// STOP  | frozen, prescaler keeps its partial count
// OVF   | reached 59:59.99, only reset leaves
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int CLK_FREQ = 25_000_000,
  parameter int TICK_HZ  = 100
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              btn_start_stop,
  input  logic              btn_reset,
  input  logic              btn_lap,
  output logic              running,
  output logic              ovf,
  output logic [TIME_W-1:0] time_bcd,
  output logic [TIME_W-1:0] lap_bcd,
  output logic              lap_valid
);

  localparam int PRE_TC = CLK_FREQ / TICK_HZ - 1;
  localparam int PRE_W  = (PRE_TC < 1) ? 1 : $clog2(PRE_TC + 1);
  localparam logic [PRE_W-1:0] PRE_TC_V = PRE_W'(PRE_TC);

  sw_state_e        state_q, state_d;
  logic [PRE_W-1:0] pre_q, pre_d;
  logic             hist_ss, hist_rs;
  logic             ev_ss, ev_rs;
  logic             tick, cnt_clr, max_reached;

  // History resets high so a button held through reset release is not a press.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist_ss <= 1'b1;
      hist_rs <= 1'b1;
    end else begin
      hist_ss <= btn_start_stop;
      hist_rs <= btn_reset;
    end
  end

  assign ev_ss = btn_start_stop & ~hist_ss;
  assign ev_rs = btn_reset & ~hist_rs;

  always_comb begin
    state_d = state_q;
    pre_d   = pre_q;
    tick    = 1'b0;
    cnt_clr = 1'b0;
    case (state_q)
      IDLE: begin
        if (ev_ss) begin
          state_d = RUN;
          pre_d   = '0;
        end
      end
      RUN: begin
        if (pre_q == PRE_TC_V) begin
          pre_d = '0;
          tick  = 1'b1;
        end else begin
          pre_d = pre_q + PRE_W'(1);
        end
        // A saturating tick takes precedence over a same-cycle stop so the
        // display never sits at 59:59.99 in STOP with a pending overflow.
        if (tick && max_reached) state_d = OVF;
        else if (ev_ss)          state_d = STOP;
      end
      STOP: begin
        if (ev_rs) begin
          state_d = IDLE;
          pre_d   = '0;
          cnt_clr = 1'b1;
        end else if (ev_ss) begin
          state_d = RUN;
        end
      end
      OVF: begin
        if (ev_rs) begin
          state_d = IDLE;
          pre_d   = '0;
          cnt_clr = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      pre_q   <= '0;
    end else begin
      state_q <= state_d;
      pre_q   <= pre_d;
    end
  end

  assign running = (state_q == RUN);
  assign ovf     = (state_q == OVF);

  bcd_time_counter u_cnt (
    .clk         (clk),
    .rst         (rst),
    .inc         (tick),
    .clr         (cnt_clr),
    .sat         (1'b1),
    .time_bcd    (time_bcd),
    .max_reached (max_reached)
  );

`ifdef STOPWATCH_LAP_EN
  logic hist_lap;
  logic ev_lap;

  assign ev_lap = btn_lap & ~hist_lap;

  // Lap snapshots the pre-increment time; counting is unaffected.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist_lap  <= 1'b1;
      lap_bcd   <= '0;
      lap_valid <= 1'b0;
    end else begin
      hist_lap  <= btn_lap;
      lap_valid <= 1'b0;
      if (cnt_clr) begin
        lap_bcd <= '0;
      end else if (state_q == RUN && ev_lap) begin
        lap_bcd   <= time_bcd;
        lap_valid <= 1'b1;
      end
    end
  end
`else
  logic lap_unused;
  assign lap_unused = btn_lap;
  assign lap_bcd    = '0;
  assign lap_valid  = 1'b0;
`endif

endmodule

// File: tb/tb_stopwatch_ctrl.sv
module tb_stopwatch_ctrl;

`ifdef STOPWATCH_LAP_EN
  localparam bit LAP_EN = 1'b1;
`else
  localparam bit LAP_EN = 1'b0;
`endif

  localparam int CYC_PER_TICK = 10;
  localparam int MAX_CS = 359999;

  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_STOP = 2;
  localparam int M_OVF  = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        btn_start_stop, btn_reset, btn_lap;
  logic        running, ovf, lap_valid;
  logic [23:0] time_bcd, lap_bcd;

  stopwatch_ctrl #(.CLK_FREQ(1000), .TICK_HZ(100)) dut (
    .clk            (clk),
    .rst            (rst),
    .btn_start_stop (btn_start_stop),
    .btn_reset      (btn_reset),
    .btn_lap        (btn_lap),
    .running        (running),
    .ovf            (ovf),
    .time_bcd       (time_bcd),
    .lap_bcd        (lap_bcd),
    .lap_valid      (lap_valid)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: elapsed time as an integer number of centiseconds plus
  // the number of clock cycles spent in RUN since the last tick.
  int          m_mode, m_cs, m_frac;
  bit          m_h_ss, m_h_rs, m_h_lp;
  logic [23:0] m_lap;
  bit          m_lap_v;

  task automatic check_val(input string tag, input logic [23:0] obs, input logic [23:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [23:0] to_bcd(input int cs);
    int mm, ss, cc;
    mm = cs / 6000;
    ss = (cs / 100) % 60;
    cc = cs % 100;
    return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10), 4'(cc / 10), 4'(cc % 10)};
  endfunction

  task automatic model_reset();
    m_mode  = M_IDLE;
    m_cs    = 0;
    m_frac  = 0;
    m_h_ss  = 1'b1;
    m_h_rs  = 1'b1;
    m_h_lp  = 1'b1;
    m_lap   = '0;
    m_lap_v = 1'b0;
  endtask

  task automatic model_step();
    bit e_ss, e_rs, e_lp, tk;
    e_ss = btn_start_stop && !m_h_ss;
    e_rs = btn_reset && !m_h_rs;
    e_lp = btn_lap && !m_h_lp;
    m_h_ss = btn_start_stop;
    m_h_rs = btn_reset;
    m_h_lp = btn_lap;
    m_lap_v = 1'b0;
    if (LAP_EN && m_mode == M_RUN && e_lp) begin
      m_lap   = to_bcd(m_cs);
      m_lap_v = 1'b1;
    end
    case (m_mode)
      M_IDLE: if (e_ss) begin m_mode = M_RUN; m_frac = 0; end
      M_RUN: begin
        m_frac++;
        tk = (m_frac == CYC_PER_TICK);
        if (tk) m_frac = 0;
        if (tk && m_cs == MAX_CS) m_mode = M_OVF;
        else begin
          if (tk) m_cs++;
          if (e_ss) m_mode = M_STOP;
        end
      end
      M_STOP: begin
        if (e_rs) begin m_mode = M_IDLE; m_cs = 0; m_frac = 0; m_lap = '0; end
        else if (e_ss) m_mode = M_RUN;
      end
      default: begin
        if (e_rs) begin m_mode = M_IDLE; m_cs = 0; m_frac = 0; m_lap = '0; end
      end
    endcase
  endtask

  task automatic check_all();
    check_val("running", 24'(running), 24'(m_mode == M_RUN));
    check_val("ovf", 24'(ovf), 24'(m_mode == M_OVF));
    check_val("time_bcd", time_bcd, to_bcd(m_cs));
    check_val("lap_bcd", lap_bcd, m_lap);
    check_val("lap_valid", 24'(lap_valid), 24'(m_lap_v));
  endtask

  task automatic cycle(input bit ss, input bit rs, input bit lp);
    btn_start_stop = ss;
    btn_reset      = rs;
    btn_lap        = lp;
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all();
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    bit r_ss, r_rs, r_lp;
    rst = 1'b1;
    btn_start_stop = 1'b1;
    btn_reset = 1'b0;
    btn_lap = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check_all();

    // 1: start held through reset release is not a press
    rst = 1'b0;
    for (int i = 0; i < 50; i++) cycle(1'b1, 1'b0, 1'b0);
    check_val("t1_running", 24'(running), 24'h0);
    check_val("t1_time", time_bcd, 24'h000000);
    cycle(1'b0, 1'b0, 1'b0);

    // 2: start press, 1000 RUN cycles -> 00:01.00
    cycle(1'b1, 1'b0, 1'b0);
    check_val("t2_running_rise", 24'(running), 24'h1);
    cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0);
    idle_cycles(998);
    check_val("t2_time", time_bcd, 24'h000100);
    cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 1'b0);

    // 3: stop after 127 RUN cycles, resume, 255 RUN cycles total -> 00:00.25
    cycle(1'b1, 1'b0, 1'b0);
    idle_cycles(126);
    cycle(1'b1, 1'b0, 1'b0);
    idle_cycles(20);
    check_val("t3_frozen", time_bcd, 24'h000012);
    check_val("t3_stopped", 24'(running), 24'h0);
    cycle(1'b1, 1'b0, 1'b0);
    idle_cycles(128);
    check_val("t3_resumed", time_bcd, 24'h000025);

    // 4: reset and start_stop together in STOP -> IDLE
    cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 1'b0);
    check_val("t4_time", time_bcd, 24'h000000);
    check_val("t4_running", 24'(running), 24'h0);
    cycle(1'b0, 1'b0, 1'b0);
    idle_cycles(15);
    check_val("t4_still_idle", time_bcd, 24'h000000);

    // 5: saturation at 59:59.99
    cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0);
    force dut.u_cnt.cnt_q = 24'h595998;
    #1;
    release dut.u_cnt.cnt_q;
    m_cs = MAX_CS - 1;
    check_all();
    cycle(1'b1, 1'b0, 1'b0);
    idle_cycles(20);
    check_val("t5_time", time_bcd, 24'h595999);
    check_val("t5_ovf", 24'(ovf), 24'h1);
    check_val("t5_running", 24'(running), 24'h0);
    cycle(1'b1, 1'b0, 1'b0);
    idle_cycles(12);
    check_val("t5_start_ignored", 24'(ovf), 24'h1);
    cycle(1'b0, 1'b1, 1'b0);
    check_val("t5_rst_time", time_bcd, 24'h000000);
    check_val("t5_rst_ovf", 24'(ovf), 24'h0);
    cycle(1'b0, 1'b0, 1'b0);

    // 6: lap at 00:00.37
    cycle(1'b1, 1'b0, 1'b0);
    idle_cycles(372);
    cycle(1'b0, 1'b0, 1'b1);
    check_val("t6_lap_bcd", lap_bcd, LAP_EN ? 24'h000037 : 24'h000000);
    check_val("t6_lap_valid", 24'(lap_valid), LAP_EN ? 24'h1 : 24'h0);
    cycle(1'b0, 1'b0, 1'b0);
    check_val("t6_lap_pulse_end", 24'(lap_valid), 24'h0);
    idle_cycles(29);
    check_val("t6_time_advances", time_bcd, 24'h000040);

    // asynchronous reset in the middle of a run
    @(negedge clk);
    rst = 1'b1;
    #2;
    model_reset();
    check_all();
    @(negedge clk);
    rst = 1'b0;

    // randomized button activity against the model
    r_ss = 1'b0; r_rs = 1'b0; r_lp = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 15) == 0) r_ss = ~r_ss;
      if ($urandom_range(0, 40) == 0) r_rs = ~r_rs;
      if ($urandom_range(0, 10) == 0) r_lp = ~r_lp;
      cycle(r_ss, r_rs, r_lp);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
